// File: rtl/lsu_mem.sv
// ============================================================================
// lsu_mem : RV32I load/store unit bridging the memory stage to a ready/valid
//           word bus. Optional macro: LSU_MISALIGN_TRAP_EN.   Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_mem #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] adrs,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall_M,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_adrs,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic        bus_err,
  output logic        misalign_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [1:0]  next_state;

  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        we_q;
  logic [29:0] word_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [7:0]  cnt;
  logic [31:0] rdata_q;
  logic        bus_err_q;

  logic        legal;
  logic        trap;
  logic        issue;
  logic        skip;
  logic        timeout;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [15:0] lane16;
  logic [31:0] load_val;

  assign legal = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd2) ||
                 (funct3 == 3'd4) || (funct3 == 3'd5);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  logic misalign_q;

  assign misaligned = ((funct3[1:0] == 2'b01) && adrs[0]) ||
                      ((funct3 == 3'd2) && (adrs[1:0] != 2'b00));
  assign trap         = misaligned;
  assign misalign_err = misalign_q;
`else
  assign trap         = 1'b0;
  assign misalign_err = 1'b0;
`endif

  assign issue   = req_valid && legal && !trap;
  assign skip    = req_valid && !issue;
  assign timeout = !bus_ready && (cnt == CNT_LAST);

  // Lanes come from the raw low address bits; a 4-bit shift drops overflow lanes.
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << adrs[1:0];
        wdata_calc = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << adrs[1:0];
        wdata_calc = {2{wdata[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = wdata;
      end
    endcase
  end

  assign lane16 = 16'(bus_rdata >> {off_q, 3'b000});

  always_comb begin
    load_val = 32'd0;
    case (funct3_q)
      3'd0:    load_val = {{24{lane16[7]}}, lane16[7:0]};
      3'd1:    load_val = {{16{lane16[15]}}, lane16};
      3'd2:    load_val = bus_rdata;
      3'd4:    load_val = {24'd0, lane16[7:0]};
      3'd5:    load_val = {16'd0, lane16};
      default: load_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (issue)     next_state = S_BUS;
        else if (skip) next_state = S_DONE;
      end
      S_BUS: begin
        if (bus_ready || timeout) next_state = S_DONE;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // The IDLE-cycle stall is gated by reset so a held request cannot stall during reset.
  always_comb begin
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_be    = 4'b0000;
    bus_adrs  = 32'd0;
    bus_wdata = 32'd0;
    stall_M   = 1'b0;
    case (state)
      S_IDLE: stall_M = reset && req_valid;
      S_BUS: begin
        bus_valid = 1'b1;
        bus_we    = we_q;
        bus_be    = be_q;
        bus_adrs  = {word_q, 2'b00};
        bus_wdata = wdata_q;
        stall_M   = 1'b1;
      end
      default: stall_M = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      funct3_q  <= 3'd0;
      off_q     <= 2'd0;
      we_q      <= 1'b0;
      word_q    <= 30'd0;
      be_q      <= 4'd0;
      wdata_q   <= 32'd0;
      cnt       <= 8'd0;
      rdata_q   <= 32'd0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (issue) begin
            funct3_q <= funct3;
            off_q    <= adrs[1:0];
            we_q     <= req_we;
            word_q   <= adrs[31:2];
            be_q     <= be_calc;
            wdata_q  <= wdata_calc;
            cnt      <= 8'd0;
          end else if (skip) begin
            rdata_q <= 32'd0;
          end
        end
        S_BUS: begin
          if (bus_ready) begin
            if (!we_q) rdata_q <= load_val;
          end else if (timeout) begin
            bus_err_q <= 1'b1;
            rdata_q   <= 32'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misalign_q <= 1'b0;
    else        misalign_q <= (state == S_IDLE) && req_valid && legal && trap;
  end
`endif

  assign rdata   = rdata_q;
  assign bus_err = bus_err_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem.sv
// Directed table-driven bench for lsu_mem, instantiated with TIMEOUT=4.
`default_nettype none

module tb_lsu_mem;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  funct3;
  logic [31:0] adrs;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall_M;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_adrs;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic        misalign_err;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_mem #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .funct3(funct3), .adrs(adrs), .wdata(wdata), .rdata(rdata),
    .stall_M(stall_M), .bus_valid(bus_valid), .bus_we(bus_we),
    .bus_adrs(bus_adrs), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err),
    .misalign_err(misalign_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  f3;
    logic        we;
    logic [31:0] adrs;
    logic [31:0] wdata;
    logic [31:0] brd;
    int          delay;
    logic [3:0]  be;
    logic [31:0] badrs;
    logic [31:0] bwdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input int idx, input vec_t v);
    req_valid = 1'b1;
    funct3    = v.f3;
    req_we    = v.we;
    adrs      = v.adrs;
    wdata     = v.wdata;
    bus_rdata = v.brd;
    bus_ready = 1'b0;
    #1;
    chk($sformatf("v%0d_idle_stall", idx), {31'd0, stall_M}, 32'd1);
    step();
    req_valid = 1'b0;
    for (int i = 0; i <= v.delay; i++) begin
      if (i == v.delay) bus_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_c%0d_valid", idx, i), {31'd0, bus_valid}, 32'd1);
      chk($sformatf("v%0d_c%0d_stall", idx, i), {31'd0, stall_M}, 32'd1);
      chk($sformatf("v%0d_c%0d_adrs", idx, i), bus_adrs, v.badrs);
      chk($sformatf("v%0d_c%0d_be", idx, i), {28'd0, bus_be}, {28'd0, v.be});
      chk($sformatf("v%0d_c%0d_we", idx, i), {31'd0, bus_we}, {31'd0, v.we});
      chk($sformatf("v%0d_c%0d_wdata", idx, i), bus_wdata, v.bwdata);
      step();
    end
    bus_ready = 1'b0;
    #1;
    chk($sformatf("v%0d_done_stall", idx), {31'd0, stall_M}, 32'd0);
    chk($sformatf("v%0d_done_valid", idx), {31'd0, bus_valid}, 32'd0);
    chk($sformatf("v%0d_done_rdata", idx), rdata, v.rdata);
    chk($sformatf("v%0d_done_err", idx), {31'd0, bus_err}, 32'd0);
    step();
  endtask

  initial begin
    //           f3    we    adrs        wdata         bus_rdata     dly be       bus_adrs    bus_wdata     rdata
    vecs[0] = '{3'd0, 1'b0, 32'h103, 32'h0,        32'h80FFFFFF, 0, 4'b1000, 32'h100, 32'h0,        32'hFFFFFF80};
    vecs[1] = '{3'd1, 1'b1, 32'h202, 32'h1234ABCD, 32'h0,        0, 4'b1100, 32'h200, 32'hABCDABCD, 32'hFFFFFF80};
    vecs[2] = '{3'd4, 1'b0, 32'h101, 32'h0,        32'h00009A00, 0, 4'b0010, 32'h100, 32'h0,        32'h0000009A};
    vecs[3] = '{3'd1, 1'b0, 32'h402, 32'h0,        32'h80017FFF, 2, 4'b1100, 32'h400, 32'h0,        32'hFFFF8001};
    vecs[4] = '{3'd5, 1'b0, 32'h400, 32'h0,        32'h1234F00D, 0, 4'b0011, 32'h400, 32'h0,        32'h0000F00D};
    vecs[5] = '{3'd2, 1'b0, 32'h500, 32'h0,        32'hDEADBEEF, 3, 4'b1111, 32'h500, 32'h0,        32'hDEADBEEF};
    vecs[6] = '{3'd0, 1'b1, 32'h603, 32'h000000A5, 32'h0,        0, 4'b1000, 32'h600, 32'hA5A5A5A5, 32'hDEADBEEF};
    vecs[7] = '{3'd2, 1'b1, 32'h700, 32'hCAFEF00D, 32'h0,        1, 4'b1111, 32'h700, 32'hCAFEF00D, 32'hDEADBEEF};
    vecs[8] = '{3'd0, 1'b0, 32'h100, 32'h0,        32'h0000007F, 0, 4'b0001, 32'h100, 32'h0,        32'h0000007F};

    // Reset with a request held: every output must be forced low.
    reset     = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b1;
    funct3    = 3'd2;
    adrs      = 32'h0;
    wdata     = 32'hFFFFFFFF;
    bus_ready = 1'b0;
    bus_rdata = 32'h0;
    #1;
    chk("rst_stall", {31'd0, stall_M}, 32'd0);
    chk("rst_valid", {31'd0, bus_valid}, 32'd0);
    chk("rst_we", {31'd0, bus_we}, 32'd0);
    chk("rst_be", {28'd0, bus_be}, 32'd0);
    chk("rst_adrs", bus_adrs, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_errs", {30'd0, bus_err, misalign_err}, 32'd0);
    req_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();

    for (int i = 0; i < 9; i++) do_txn(i, vecs[i]);

    // Reserved funct3: no bus cycle, straight to DONE with rdata cleared.
    funct3    = 3'd3;
    req_we    = 1'b0;
    adrs      = 32'h104;
    req_valid = 1'b1;
    #1;
    chk("ill_idle_stall", {31'd0, stall_M}, 32'd1);
    step();
    req_valid = 1'b0;
    #1;
    chk("ill_valid", {31'd0, bus_valid}, 32'd0);
    chk("ill_stall", {31'd0, stall_M}, 32'd0);
    chk("ill_rdata", rdata, 32'd0);
    chk("ill_errs", {30'd0, bus_err, misalign_err}, 32'd0);
    step();

    do_txn(100, vecs[5]);

    // Timeout: bus_ready held low for TIMEOUT=4 BUS cycles.
    funct3    = 3'd2;
    req_we    = 1'b0;
    adrs      = 32'h800;
    bus_ready = 1'b0;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("to_c%0d_valid", i), {31'd0, bus_valid}, 32'd1);
      chk($sformatf("to_c%0d_err", i), {31'd0, bus_err}, 32'd0);
      step();
    end
    #1;
    chk("to_done_err", {31'd0, bus_err}, 32'd1);
    chk("to_done_rdata", rdata, 32'd0);
    chk("to_done_stall", {31'd0, stall_M}, 32'd0);
    chk("to_done_valid", {31'd0, bus_valid}, 32'd0);
    step();
    #1;
    chk("to_after_err", {31'd0, bus_err}, 32'd0);
    chk("to_after_valid", {31'd0, bus_valid}, 32'd0);
    step();

    // Misaligned LW at 0x301.
    funct3    = 3'd2;
    req_we    = 1'b0;
    adrs      = 32'h301;
    bus_rdata = 32'h11223344;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    #1;
    chk("mis_valid", {31'd0, bus_valid}, 32'd0);
    chk("mis_err", {31'd0, misalign_err}, 32'd1);
    chk("mis_rdata", rdata, 32'd0);
    chk("mis_stall", {31'd0, stall_M}, 32'd0);
    step();
    #1;
    chk("mis_err_after", {31'd0, misalign_err}, 32'd0);
    chk("mis_valid_after", {31'd0, bus_valid}, 32'd0);
`else
    bus_ready = 1'b1;
    #1;
    chk("mis_valid", {31'd0, bus_valid}, 32'd1);
    chk("mis_adrs", bus_adrs, 32'h300);
    chk("mis_be", {28'd0, bus_be}, 32'hF);
    chk("mis_err", {31'd0, misalign_err}, 32'd0);
    step();
    bus_ready = 1'b0;
    #1;
    chk("mis_rdata", rdata, 32'h11223344);
    chk("mis_stall", {31'd0, stall_M}, 32'd0);
`endif
    step();

    // Asynchronous reset mid-BUS with bus_ready low.
    funct3    = 3'd2;
    adrs      = 32'h900;
    bus_ready = 1'b0;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    #1;
    chk("arst_pre_valid", {31'd0, bus_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", {31'd0, bus_valid}, 32'd0);
    chk("arst_stall", {31'd0, stall_M}, 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("arst_post%0d", i),
          {29'd0, bus_valid, stall_M, bus_err}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu_mem.md
LSU_MEM -- requirements
Module: lsu_mem

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, the maximum number of bus wait cycles allowed before a transaction is aborted (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, the asynchronous active-low reset (0 = reset asserted).
REQ-004 SHALL have port req_valid, input, 1, memory-stage load/store request.
REQ-005 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port funct3, input, 3, the RV32I load/store width and sign code.
REQ-007 SHALL have port adrs, input, 32, the byte address (the ALU result).
REQ-008 SHALL have port wdata, input, 32, the store data (rs2).
REQ-009 SHALL have port rdata, output, 32, the aligned and extended load result, which feeds the pipeline's memory read-data input.
REQ-010 SHALL have port stall_M, output, 1, which holds the pipeline while a transaction is pending.
REQ-011 SHALL have port bus_valid, output, 1, the bus request.
REQ-012 SHALL have port bus_we, output, 1, the bus write strobe.
REQ-013 SHALL have port bus_adrs, output, 32, the word address with bits [1:0] = 0.
REQ-014 SHALL have port bus_wdata, output, 32, the lane-shifted store data.
REQ-015 SHALL have port bus_be, output, 4, the byte enables.
REQ-016 SHALL have port bus_ready, input, 1, the bus completion signal.
REQ-017 SHALL have port bus_rdata, input, 32, the raw bus word.
REQ-018 SHALL have port bus_err, output, 1, a one-cycle timeout pulse.
REQ-019 SHALL have port misalign_err, output, 1, a one-cycle misaligned-access pulse.

Function
REQ-020 SHALL implement FSM states IDLE, BUS, DONE.
REQ-021 In IDLE, a request with req_valid=1 and a legal funct3 SHALL latch the request fields and enter BUS on the next edge.
  - stall_M=1 combinationally during that IDLE cycle.
REQ-022 In BUS, bus_valid=1 and all bus_* outputs SHALL stay stable until bus_ready=1.
  - stall_M=1 throughout BUS.
REQ-023 On bus_ready=1 in BUS, the block SHALL register the load result into rdata and enter DONE.
REQ-024 In DONE, stall_M=0 and rdata SHALL be valid; the next state is always IDLE, and req_valid is ignored in DONE.
REQ-025 Minimum latency SHALL be 3 cycles from request to DONE when bus_ready=1 on the first BUS cycle.
REQ-026 Byte enables: funct3 0/4 SHALL give 4'b0001<<adrs[1:0]; 1/5 SHALL give 4'b0011<<adrs[1:0]; 2 SHALL give 4'b1111.
REQ-027 bus_wdata SHALL be wdata replicated into the lanes selected by bus_be.
REQ-028 Load extraction SHALL shift bus_rdata right by 8*adrs[1:0].
  - LB/LH (0/1) sign-extend; LBU/LHU (4/5) zero-extend; LW (2) passes the word unchanged.
REQ-029 funct3 3, 6 or 7 SHALL issue no bus transaction and pass IDLE->DONE with rdata=0 and no error.
REQ-030 A BUS-state counter SHALL count cycles with bus_ready=0.
  - On reaching TIMEOUT it aborts: bus_err pulses for 1 cycle, rdata=0, and the state goes to DONE.
  - bus_ready arriving on the same cycle as the count reaching TIMEOUT counts as success, with no bus_err.
REQ-031 A store SHALL leave rdata unchanged from its previous value.

Reset
REQ-032 reset=0 SHALL immediately force IDLE and clear the counter.
  - Forced outputs: rdata=0, bus_valid=0, bus_we=0, bus_be=0, bus_adrs=0, bus_wdata=0.
  - Forced outputs: stall_M=0, bus_err=0, misalign_err=0.
REQ-033 A reset asserted during BUS SHALL drop bus_valid asynchronously, with no completion pulse after release.

Configuration
REQ-034 Macro LSU_MISALIGN_TRAP_EN SHALL control misaligned-access handling.
  - Defined: LH/LHU/SH with adrs[0]=1, or LW/SW with adrs[1:0]!=0, issues no bus transaction and goes IDLE->DONE; misalign_err pulses 1 cycle in DONE and rdata=0.
  - Undefined: misaligned requests issue normally with bus_adrs forced to the aligned word; lanes are computed from adrs[1:0] and masked to 4 bits; misalign_err is tied 0.

Verification
REQ-035 LB at adrs=0x103 with bus_rdata=0x80FFFFFF and bus_ready on the first BUS cycle SHALL give bus_be=0001<<3=1000, rdata=0xFFFFFF80 in DONE, and a 3-cycle stall-to-release.
REQ-036 SH at adrs=0x202 with wdata=0x1234ABCD SHALL give bus_adrs=0x200, bus_be=1100, bus_we=1, and bus_wdata[31:16]=0xABCD.
REQ-037 With TIMEOUT=4 and bus_ready held 0, bus_err SHALL pulse once after 4 BUS cycles, with rdata=0 and stall_M released in DONE.
REQ-038 LW at adrs=0x301 SHALL, with the macro defined, pulse misalign_err with no bus_valid; without the macro, it SHALL issue bus_adrs=0x300 with bus_be=1111.
REQ-039 Driving reset=0 mid-BUS with bus_ready=0 SHALL drop bus_valid and stall_M in the same cycle and return to IDLE after release.
